noc_interface_param: RTL

Parametrised CPU-to-router network interface, the next generation of the core's NoC endpoint. Sits between the RV32IM core's memory-mapped data port and the router's local port. Buffers outbound {destination index, payload} flits in a TX FIFO and inbound flits in an RX FIFO, with valid/ready handshakes on the router side. Exposes a status register with levels and sticky error flags, plus a maskable interrupt.

---
 rtl/noc_interface_param_if.sv | 39 +++
 rtl/noc_interface_param.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/noc_interface_param_if.sv
// noc_interface_param_if
//   Bundles the CPU memory-mapped port and both router handshake channels
//   of the NoC endpoint.
//   CPU side   : addr_cpu, data_out_cpu (write data), data_in_cpu (read data),
//                write_en_cpu, read_en_cpu
//   Router TX  : tx_flit, tx_valid, tx_ready
//   Router RX  : rx_flit, rx_valid, rx_ready
//   Status/irq : status, irq
//   modport slave is the endpoint itself; master is the CPU/router environment.
interface noc_interface_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 32
);
    logic [31:0]             addr_cpu;
    logic [31:0]             data_out_cpu;
    logic [31:0]             data_in_cpu;
    logic                    write_en_cpu;
    logic                    read_en_cpu;
    logic [IDX_W+DATA_W-1:0] tx_flit;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [IDX_W+DATA_W-1:0] rx_flit;
    logic                    rx_valid;
    logic                    rx_ready;
    logic [31:0]             status;
    logic                    irq;

    modport master (
        output addr_cpu, data_out_cpu, write_en_cpu, read_en_cpu,
        output tx_ready, rx_flit, rx_valid,
        input  data_in_cpu, tx_flit, tx_valid, rx_ready, status, irq
    );

    modport slave (
        input  addr_cpu, data_out_cpu, write_en_cpu, read_en_cpu,
        input  tx_ready, rx_flit, rx_valid,
        output data_in_cpu, tx_flit, tx_valid, rx_ready, status, irq
    );
endinterface

// File: rtl/noc_interface_param.sv
// noc_interface_param
//   CPU-to-router network endpoint. Outbound {index, payload} flits are queued
//   in a TX FIFO, inbound flits in an RX FIFO. A four-word register window
//   (addr_cpu[3:2]) gives access to the TX index / RX head index (0),
//   TX push / last RX payload (1), STATUS with W1C sticky errors (2) and
//   CTRL interrupt enables (3).
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : noc_interface_param_if.slave (CPU port, router TX/RX, status, irq)
module noc_interface_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IDX_W     = 32,
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16,
    parameter int unsigned TX_THRESH = 12,
    parameter int unsigned RX_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    noc_interface_param_if.slave    bus
);
    localparam int unsigned FLIT_W = IDX_W + DATA_W;
    localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
    localparam int unsigned TX_CW  = TX_AW + 1;
    localparam int unsigned RX_CW  = RX_AW + 1;

    // Storage and state
    logic [FLIT_W-1:0] tx_mem_q [TX_DEPTH];
    logic [FLIT_W-1:0] rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_q, tx_rd_q;
    logic [RX_AW-1:0]  rx_wr_q, rx_rd_q;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]  tx_index_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [2:0]        ctrl_q;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_udf_q, rx_udf_d;
    logic              irq_q, irq_d;

    // Decode
    logic [1:0]  reg_sel;
    logic        tx_full, tx_empty, tx_thresh;
    logic        rx_full, rx_empty, rx_thresh;
    logic        tx_push_req, tx_push, tx_pop, tx_ovf_evt;
    logic        rx_pop_req, rx_pop, rx_push, rx_udf_evt;
    logic        w1c_wr;
    logic [FLIT_W-1:0] rx_head;
    logic [31:0] status_w;
    logic [31:0] rd_data;

    assign reg_sel   = bus.addr_cpu[3:2];

    assign tx_full   = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_thresh = (32'(tx_cnt_q) >= TX_THRESH);
    assign rx_full   = (rx_cnt_q == RX_CW'(RX_DEPTH));
    assign rx_empty  = (rx_cnt_q == '0);
    assign rx_thresh = (32'(rx_cnt_q) >= RX_THRESH);

    // A pop on the same edge frees the slot, so a push into a full TX FIFO
    // still lands when the router drains concurrently.
    assign tx_push_req = bus.write_en_cpu && (reg_sel == 2'd1);
    assign tx_pop      = !tx_empty && bus.tx_ready;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_evt  = tx_push_req && tx_full && !tx_pop;

    // An RX push on an empty FIFO cannot satisfy a same-cycle pop.
    assign rx_pop_req  = bus.read_en_cpu && (reg_sel == 2'd0);
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign rx_udf_evt  = rx_pop_req && rx_empty;
    assign rx_push     = bus.rx_valid && !rx_full;

    assign w1c_wr      = bus.write_en_cpu && (reg_sel == 2'd2);

    assign rx_head     = rx_mem_q[rx_rd_q];

    assign status_w = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q),
                       rx_udf_q, rx_thresh, rx_empty, rx_full,
                       tx_ovf_q, tx_thresh, tx_empty, tx_full};

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + TX_CW'(1);
        else if (!tx_push && tx_pop)
            tx_cnt_d = tx_cnt_q - TX_CW'(1);

        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + RX_CW'(1);
        else if (!rx_push && rx_pop)
            rx_cnt_d = rx_cnt_q - RX_CW'(1);

        // New error events take priority over a W1C clear in the same cycle.
        tx_ovf_d = tx_ovf_evt || (tx_ovf_q && !(w1c_wr && bus.data_out_cpu[3]));
        rx_udf_d = rx_udf_evt || (rx_udf_q && !(w1c_wr && bus.data_out_cpu[7]));

        irq_d = (ctrl_q[0] && !rx_empty) ||
                (ctrl_q[1] && rx_thresh) ||
                (ctrl_q[2] && (tx_ovf_q || rx_udf_q));
    end

    always_comb begin
        rd_data = '0;
        if (bus.read_en_cpu) begin
            case (reg_sel)
                2'd0: if (!rx_empty) rd_data = 32'(rx_head[FLIT_W-1:DATA_W]);
                2'd1: rd_data = 32'(rx_data_q);
                2'd2: rd_data = status_w;
                default: rd_data = {29'b0, ctrl_q};
            endcase
        end
    end

    // FIFO storage carries no reset; validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem_q[tx_wr_q] <= {tx_index_q, bus.data_out_cpu[DATA_W-1:0]};
        if (rx_push)
            rx_mem_q[rx_wr_q] <= bus.rx_flit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_index_q <= '0;
            rx_data_q  <= '0;
            ctrl_q     <= '0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TX_AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TX_AW'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + RX_AW'(1);
            if (rx_pop) begin
                rx_rd_q   <= rx_rd_q + RX_AW'(1);
                rx_data_q <= rx_head[DATA_W-1:0];
            end
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (bus.write_en_cpu && (reg_sel == 2'd0))
                tx_index_q <= IDX_W'(bus.data_out_cpu);
            if (bus.write_en_cpu && (reg_sel == 2'd3))
                ctrl_q <= bus.data_out_cpu[2:0];
            tx_ovf_q <= tx_ovf_d;
            rx_udf_q <= rx_udf_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.tx_flit     = tx_mem_q[tx_rd_q];
    assign bus.tx_valid    = !tx_empty;
    assign bus.rx_ready    = !rx_full;
    assign bus.status      = status_w;
    assign bus.irq         = irq_q;
    assign bus.data_in_cpu = rd_data;

    // Address bits outside the word select are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_cpu[31:4], bus.addr_cpu[1:0]};
endmodule
